// File: rtl/memory_sb_pkg.sv
// Shared types for the memory stage: pipeline bundles, data-bus request/response,
// store-buffer entry, bus FSM states and access-size constants.
package memory_sb_pkg;

    localparam logic [2:0] MSize1 = 3'd0;
    localparam logic [2:0] MSize2 = 3'd1;
    localparam logic [2:0] MSize4 = 3'd2;
    localparam logic [2:0] MSize8 = 3'd3;

    typedef enum logic [1:0] {OpAlu, OpLoad, OpStore} op_t;

    typedef struct packed {
        op_t op;
    } control_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] rd2;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] addr;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [60:0] addr_hi;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [2:0]  size;
    } sb_entry_t;

    typedef enum logic [1:0] {StIdle, StLoad, StStore} mem_state_t;

    function automatic logic [7:0] byte_mask(input logic [2:0] size);
        case (size)
            MSize1:  return 8'h01;
            MSize2:  return 8'h03;
            MSize4:  return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        case (size)
            MSize1:  return 3'd0;
            MSize2:  return 3'd1;
            MSize4:  return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/memory_sb_store_buffer.sv
// Posted-store FIFO: circular entries with wrapping pointers and a separate count,
// plus a per-slot match vector against a doubleword address.
module store_buffer
    import memory_sb_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    localparam int unsigned PtrW = $clog2(SB_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  sb_entry_t           push_entry,
    input  logic                pop,
    input  logic [60:0]         match_addr,
    output sb_entry_t           head,
    output logic [CntW-1:0]     count,
    output logic [SB_DEPTH-1:0] match_vec
);

    sb_entry_t       entries [SB_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] slot_off [SB_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr_q] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot_off[i]  = PtrW'(i) - rd_ptr_q;
            match_vec[i] = ({1'b0, slot_off[i]} < count_q) && (entries[i].addr_hi == match_addr);
        end
    end

    assign head  = entries[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/memory_sb.sv
// Memory stage with a posted-store buffer: stores retire into the buffer and drain
// over the data bus; loads wait out address conflicts and go to the bus when idle.
module memory_sb
    import memory_sb_pkg::*;
#(
    parameter int unsigned SB_DEPTH     = 4,
    parameter int unsigned MISALIGN_CHK = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    input  logic         fence,
    output memory_data_t dataM,
    output logic         misalignM,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output logic         stopm,
    output logic         sb_empty
);

    localparam int unsigned CntW = $clog2(SB_DEPTH) + 1;

    mem_state_t          state_q, state_d;
    memory_data_t        data_m_q, data_m_d;
    logic                misalign_q;
    sb_entry_t           head, push_entry;
    logic [CntW-1:0]     sb_count;
    logic [SB_DEPTH-1:0] match_vec;

    logic [2:0]  acc_size, offset;
    logic        ld_unsigned, is_load, is_store, misalign, ld_ok, sd_ok;
    logic        conflict, full, fence_stall, ld_go, load_done, push, pop;
    logic [63:0] shifted, ld_val;

    assign acc_size    = {1'b0, dataE.raw_instr[13:12]};
    assign ld_unsigned = dataE.raw_instr[14];
    assign offset      = dataE.result[2:0];
    assign is_load     = dataE.valid && (dataE.ctl.op == OpLoad);
    assign is_store    = dataE.valid && (dataE.ctl.op == OpStore);
    assign misalign    = (MISALIGN_CHK != 0) && ((offset & align_mask(acc_size)) != 3'd0);
    assign ld_ok       = is_load && !misalign;
    assign sd_ok       = is_store && !misalign;

    assign conflict    = |match_vec;
    assign full        = (sb_count == CntW'(SB_DEPTH));
    assign sb_empty    = (sb_count == '0) && (state_q != StStore);
    assign fence_stall = fence && !sb_empty;
    assign ld_go       = ld_ok && !conflict && !fence_stall;
    assign load_done   = (state_q == StLoad) && dresp.data_ok;
    assign stopm       = fence_stall || (sd_ok && full) || (ld_ok && !load_done);
    assign push        = sd_ok && !stopm;
    assign pop         = (state_q == StStore) && dresp.data_ok;

    assign push_entry.addr_hi = dataE.result[63:3];
    assign push_entry.strobe  = byte_mask(acc_size) << offset;
    assign push_entry.data    = dataE.rd2 << {offset, 3'b000};
    assign push_entry.size    = acc_size;

    store_buffer #(
        .SB_DEPTH(SB_DEPTH)
    ) u_store_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .match_addr(dataE.result[63:3]),
        .head      (head),
        .count     (sb_count),
        .match_vec (match_vec)
    );

    always_comb begin
        shifted = dresp.data >> {offset, 3'b000};
        case (acc_size)
            MSize1:  ld_val = ld_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
            MSize2:  ld_val = ld_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            MSize4:  ld_val = ld_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ld_val = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ld_go)                state_d = StLoad;
                else if (sb_count != '0)  state_d = StStore;
            end
            StLoad, StStore: begin
                if (dresp.data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request is a pure function of state plus held inputs, so it is stable until data_ok.
    always_comb begin
        dreq = '0;
        case (state_q)
            StLoad: begin
                dreq.valid = 1'b1;
                dreq.addr  = dataE.result;
                dreq.size  = acc_size;
            end
            StStore: begin
                dreq.valid  = 1'b1;
                dreq.addr   = {head.addr_hi, 3'b000};
                dreq.size   = head.size;
                dreq.strobe = head.strobe;
                dreq.data   = head.data;
            end
            default: dreq = '0;
        endcase
    end

    always_comb begin
        data_m_d           = '0;
        data_m_d.valid     = dataE.valid;
        data_m_d.pc        = dataE.pc;
        data_m_d.raw_instr = dataE.raw_instr;
        data_m_d.ctl       = dataE.ctl;
        data_m_d.dst       = dataE.dst;
        data_m_d.addr      = dataE.result;
        data_m_d.result    = ld_ok ? ld_val : dataE.result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            data_m_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (stopm) begin
                data_m_q.valid <= 1'b0;
                misalign_q     <= 1'b0;
            end else begin
                data_m_q   <= data_m_d;
                misalign_q <= (is_load || is_store) && misalign;
            end
        end
    end

    assign dataM     = data_m_q;
    assign misalignM = misalign_q;

endmodule

// File: doc/memory_sb.md
MEMORY_SB -- requirements
Module: memory_sb

Interface
REQ-001 Parameter SB_DEPTH, default 4, SHALL set the number of posted-store buffer entries (power of two, >=2).
REQ-002 Parameter MISALIGN_CHK, default 1, SHALL enable misalignment detection when 1; when 0, accesses SHALL pass unchecked.
REQ-003 clk  input  1  clock; all state SHALL update on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dataE  input  excute_data_t  execute-stage bundle: valid, pc, raw_instr, ctl.op, dst, result (address/ALU), rd2 (store data).
REQ-006 fence  input  1  drain request; the stage SHALL stall until the store buffer is empty.
REQ-007 dataM  output  memory_data_t  registered memory-stage bundle.
REQ-008 misalignM  output  1  registered; 1 when the instruction in dataM faulted on alignment.
REQ-009 dreq  output  dbus_req_t  data-bus request (valid, addr, size, strobe, data).
REQ-010 dresp  input  dbus_resp_t  data-bus response (data_ok, data).
REQ-011 stopm  output  1  combinational stall to upstream stages.
REQ-012 sb_empty  output  1  1 when the buffer holds no entries and no store is in flight.

Function
REQ-013 f3 = raw_instr[14:12] SHALL decode to size/sign: 000 B signed, 100 B unsigned, 001 H, 101 HU, 010 W, 110 WU, others D.
REQ-014 Misaligned (MISALIGN_CHK=1): address not a multiple of the access size; such LD/SD SHALL NOT touch the bus or the buffer, SHALL NOT stall, and SHALL set misalignM with dataM.
REQ-015 A valid aligned SD with count<SB_DEPTH SHALL enqueue {addr[63:3], strobe, lane-shifted data, size} and complete without stall.
REQ-016 SD with count==SB_DEPTH SHALL assert stopm; "full" uses the registered count, so same-cycle dequeue does not free a slot.
REQ-017 A valid aligned LD SHALL assert stopm while any buffered or in-flight store matches addr[63:3].
REQ-018 A non-conflicting LD SHALL assert stopm until its dresp.data_ok; on data_ok, the loaded value SHALL be lane-extracted and sign/zero-extended into dataM.result.
REQ-019 Bus FSM states: IDLE, LOAD, STORE. IDLE->LOAD when a non-conflicting LD is pending; else IDLE->STORE when the buffer is non-empty. LOAD/STORE->IDLE on data_ok.
REQ-020 Once dreq.valid is raised, valid/addr/size/strobe/data SHALL stay constant until data_ok.
REQ-021 Loads SHALL have priority over buffer drain only when the FSM is IDLE; an in-progress STORE SHALL finish first.
REQ-022 STORE data_ok SHALL dequeue the head entry; rd/wr pointers SHALL wrap modulo SB_DEPTH, tracked by a separate count.
REQ-023 Non-memory ops SHALL pass result through with no stall and no bus activity.
REQ-024 Each cycle: stopm=1 -> dataM.valid<=0; else dataM<=next bundle, with addr = dataE.result.
REQ-025 fence=1 SHALL assert stopm until sb_empty=1.
REQ-026 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.

Reset
REQ-027 On reset, dataM.valid=0, misalignM=0, count=0, pointers=0, FSM=IDLE, and dreq.valid SHALL be 0 in the following cycle, even mid-transaction; buffered stores SHALL be discarded.

Structure
REQ-028 sb_entry_t and the mem_state_t enum SHALL be in the shared pipes package; the size-decode constants SHALL be in common.
REQ-029 The FIFO SHALL be a sub-module store_buffer (parameter SB_DEPTH) exporting head, count, and a conflict match vector.

Verification
REQ-030 SD 0x8000_0010 D=0x1122334455667788, then LD D 0x8000_0010 -> LD stalls until the store's data_ok, then result=0x1122334455667788.
REQ-031 Five back-to-back SDs with data_ok held low (SB_DEPTH=4) -> four accepted without stall; stopm=1 on the fifth until the first data_ok.
REQ-032 LB 0x8000_0003 with bus data 0x00000000_80000000 and byte 0x80 -> result 0xFFFFFFFFFFFFFF80; LBU -> 0x80.
REQ-033 LW 0x8000_0002 -> misalignM=1, dreq.valid never asserted, stopm=0.
REQ-034 Assert reset while a STORE waits for data_ok with 3 entries -> next cycle dreq.valid=0, sb_empty=1, dataM.valid=0.
REQ-035 Three SDs, then fence, with data_ok after 2 cycles each -> stopm stays high until the third data_ok, then sb_empty=1.
